// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter.
//   arb_state_t : command FSM state (ARB, WR_LOCK)
//   tag_t       : read tag stored per outstanding read {client id, burstcount}
//   next_client : round-robin successor of a client index
// The client count and burst width live here rather than on the modules,
// because the packed tag struct depends on them.
package dram_arb_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int BURST_W     = 7;
  localparam int CLIENT_ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [0:0] {
    ARB     = 1'b0,
    WR_LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [CLIENT_ID_W-1:0] id;
    logic [BURST_W-1:0]     burstcount;
  } tag_t;

  function automatic logic [CLIENT_ID_W-1:0] next_client(input logic [CLIENT_ID_W-1:0] id);
    if (int'(id) == NUM_CLIENTS - 1) return '0;
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Bundle of the client-side Avalon-MM command/response signals and the
// EMIF-side master port handled by dram_port_arbiter.
//   slave  : arbiter view (takes client requests and EMIF responses,
//            drives client stalls/valids and EMIF commands)
//   master : environment view (clients plus EMIF), the mirror image
// Parameters: ADDR_W (word address width), DATA_W (data width).
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 512
);
  import dram_arb_pkg::*;

  // Client side
  logic [NUM_CLIENTS-1:0]              cl_read;
  logic [NUM_CLIENTS-1:0]              cl_write;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  cl_address;
  logic [NUM_CLIENTS-1:0][BURST_W-1:0] cl_burstcount;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  cl_writedata;
  logic [NUM_CLIENTS-1:0]              cl_urgent;
  logic [NUM_CLIENTS-1:0]              cl_waitrequest;
  logic [NUM_CLIENTS-1:0]              cl_readdatavalid;
  logic [DATA_W-1:0]                   cl_readdata;

  // EMIF side
  logic                                dram_waitrequest;
  logic [DATA_W-1:0]                   dram_readdata;
  logic                                dram_readdatavalid;
  logic [ADDR_W-1:0]                   dram_address;
  logic [BURST_W-1:0]                  dram_burstcount;
  logic [DATA_W-1:0]                   dram_writedata;
  logic                                dram_read;
  logic                                dram_write;

  modport slave (
    input  cl_read, cl_write, cl_address, cl_burstcount, cl_writedata, cl_urgent,
    output cl_waitrequest, cl_readdatavalid, cl_readdata,
    input  dram_waitrequest, dram_readdata, dram_readdatavalid,
    output dram_address, dram_burstcount, dram_writedata, dram_read, dram_write
  );

  modport master (
    output cl_read, cl_write, cl_address, cl_burstcount, cl_writedata, cl_urgent,
    input  cl_waitrequest, cl_readdatavalid, cl_readdata,
    output dram_waitrequest, dram_readdata, dram_readdatavalid,
    input  dram_address, dram_burstcount, dram_writedata, dram_read, dram_write
  );

endinterface

// File: rtl/dram_arb_tag_fifo.sv
// In-order FIFO of read tags, one entry per outstanding read command.
// The head is read combinationally so returning beats can be routed in the
// same cycle they arrive.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push_i      : write push_tag_i (ignored when full)
//   push_tag_i  : tag to store
//   pop_i       : drop the head entry (ignored when empty)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
//   head_o      : oldest entry
module dram_arb_tag_fifo
  import dram_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  tag_t push_tag_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output tag_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one Avalon-MM EMIF master port between NUM_CLIENTS requesters.
// Commands are arbitrated round-robin with an urgent override, write bursts
// are kept atomic, and read beats are routed back to their issuer through an
// in-order tag FIFO. The command path is purely combinational.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : client and EMIF signals (dram_port_arbiter_if.slave)
//   route_err    : sticky, read beat arrived with no outstanding tag
//   perf_grants  : per-client accepted-command counters
//   perf_stall   : EMIF backpressure cycle counter
// Optional build macro DRAM_ARB_PERF_EN builds the performance counters;
// without it perf_grants/perf_stall are constant 0.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  dram_port_arbiter_if.slave           bus,
  output logic                         route_err,
  output logic [NUM_CLIENTS-1:0][31:0] perf_grants,
  output logic [31:0]                  perf_stall
);

  arb_state_t             state_q;
  logic [CLIENT_ID_W-1:0] rr_ptr_q, lock_id_q;
  logic [BURST_W-1:0]     wbeats_q, rbeats_q;
  logic                   route_err_q;

  logic                   fifo_full, fifo_empty, fifo_pop;
  tag_t                   fifo_head, push_tag;

  logic [NUM_CLIENTS-1:0] eligible, urgent_elig;
  logic [CLIENT_ID_W-1:0] grant;
  logic                   grant_valid;
  logic                   rd_acc, wr_acc;

  // ---------------- Grant selection ----------------
  always_comb begin
    eligible    = bus.cl_write | (bus.cl_read & {NUM_CLIENTS{!fifo_full}});
    urgent_elig = eligible & bus.cl_urgent;
    grant       = '0;
    grant_valid = 1'b0;
    if (state_q == WR_LOCK) begin
      grant       = lock_id_q;
      grant_valid = 1'b1;
    end else if (|urgent_elig) begin
      // Ascending scan: the highest-index urgent client is assigned last.
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (urgent_elig[i]) grant = CLIENT_ID_W'(i);
      grant_valid = 1'b1;
    end else if (|eligible) begin
      // Lowest eligible index overall is the wrap-around fallback; the
      // second scan overrides it with the lowest eligible index >= rr_ptr.
      for (int i = NUM_CLIENTS - 1; i >= 0; i--)
        if (eligible[i]) grant = CLIENT_ID_W'(i);
      for (int i = NUM_CLIENTS - 1; i >= 0; i--)
        if (eligible[i] && i >= int'(rr_ptr_q)) grant = CLIENT_ID_W'(i);
      grant_valid = 1'b1;
    end
  end

  // ---------------- Command mux ----------------
  always_comb begin
    bus.dram_address    = bus.cl_address[grant];
    bus.dram_burstcount = bus.cl_burstcount[grant];
    bus.dram_writedata  = bus.cl_writedata[grant];
    bus.dram_read       = 1'b0;
    bus.dram_write      = 1'b0;
    bus.cl_waitrequest  = '1;
    if (grant_valid && !reset) begin
      // Reads are never forwarded while a write burst holds the port.
      bus.dram_read             = bus.cl_read[grant] && (state_q == ARB);
      bus.dram_write            = bus.cl_write[grant];
      bus.cl_waitrequest[grant] = bus.dram_waitrequest;
    end
  end

  assign rd_acc   = bus.dram_read && !bus.dram_waitrequest;
  assign wr_acc   = bus.dram_write && !bus.dram_waitrequest;
  assign push_tag = '{id: grant, burstcount: bus.dram_burstcount};

  // ---------------- Read return routing ----------------
  assign fifo_pop = !reset && bus.dram_readdatavalid && !fifo_empty &&
                    (rbeats_q == fifo_head.burstcount - 1'b1);
  assign bus.cl_readdata = bus.dram_readdata;

  always_comb begin
    bus.cl_readdatavalid = '0;
    if (!reset && bus.dram_readdatavalid && !fifo_empty)
      bus.cl_readdatavalid[fifo_head.id] = 1'b1;
  end

  dram_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (rd_acc),
    .push_tag_i (push_tag),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  // ---------------- Command FSM and return beat counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      wbeats_q    <= '0;
      rbeats_q    <= '0;
      route_err_q <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (rd_acc) rr_ptr_q <= next_client(grant);
          if (wr_acc) begin
            if (bus.dram_burstcount == BURST_W'(1)) begin
              rr_ptr_q <= next_client(grant);
            end else begin
              lock_id_q <= grant;
              wbeats_q  <= bus.dram_burstcount - 1'b1;
              state_q   <= WR_LOCK;
            end
          end
        end
        WR_LOCK: begin
          if (wr_acc) begin
            wbeats_q <= wbeats_q - 1'b1;
            if (wbeats_q == BURST_W'(1)) begin
              rr_ptr_q <= next_client(lock_id_q);
              state_q  <= ARB;
            end
          end
        end
        default: state_q <= ARB;
      endcase

      if (bus.dram_readdatavalid) begin
        if (fifo_empty)    route_err_q <= 1'b1;
        else if (fifo_pop) rbeats_q    <= '0;
        else               rbeats_q    <= rbeats_q + 1'b1;
      end
    end
  end

  assign route_err = route_err_q;

  // ---------------- Performance counters ----------------
`ifdef DRAM_ARB_PERF_EN
  logic [NUM_CLIENTS-1:0][31:0] perf_grants_q;
  logic [31:0]                  perf_stall_q;
  logic                         wr_done;

  // A write counts once, on the beat that completes its burst.
  assign wr_done = wr_acc && ((state_q == ARB) ? (bus.dram_burstcount == BURST_W'(1))
                                               : (wbeats_q == BURST_W'(1)));

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_perf
    always_ff @(posedge clk) begin
      if (reset)
        perf_grants_q[gi] <= '0;
      else if ((rd_acc || wr_done) && grant == CLIENT_ID_W'(gi))
        perf_grants_q[gi] <= perf_grants_q[gi] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      perf_stall_q <= '0;
    else if ((bus.dram_read || bus.dram_write) && bus.dram_waitrequest)
      perf_stall_q <= perf_stall_q + 32'd1;
  end

  assign perf_grants = perf_grants_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_grants = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed testbench for dram_port_arbiter (two clients, tag depth 16).
module tb_dram_port_arbiter;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             route_err;
  logic [1:0][31:0] perf_grants;
  logic [31:0]      perf_stall;
  int               compared = 0;
  int               mismatched = 0;

  dram_port_arbiter_if bus ();

  dram_port_arbiter #(.TAG_DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .route_err   (route_err),
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
  );

  always #5 clk = ~clk;

  // Illegal client behaviour must never be generated by the stimulus.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++)
        assert (!(bus.cl_read[i] && bus.cl_write[i])) else $error("client %0d read and write together", i);
      assert (!(bus.dram_write && bus.dram_burstcount == 7'd0)) else $error("write with zero burstcount");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cl_read       = '0;
    bus.cl_write      = '0;
    bus.cl_urgent     = '0;
  endtask

  task automatic set_client(input int c, input logic rd, input logic wr,
                            input logic [27:0] addr, input logic [6:0] bc);
    bus.cl_read[c]       = rd;
    bus.cl_write[c]      = wr;
    bus.cl_address[c]    = addr;
    bus.cl_burstcount[c] = bc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_client(0, 1'b1, 1'b0, 28'h10, 7'd1);
    bus.dram_readdatavalid = 1'b1;
    repeat (2) step();
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b11) begin mismatched++; $display("FAIL reset_waitreq: got %b want 11", bus.cl_waitrequest); end
    compared++;
    if ({bus.dram_read, bus.dram_write} !== 2'b00) begin mismatched++; $display("FAIL reset_cmd: got %b want 00", {bus.dram_read, bus.dram_write}); end
    compared++;
    if (bus.cl_readdatavalid !== 2'b00) begin mismatched++; $display("FAIL reset_rvalid: got %b want 00", bus.cl_readdatavalid); end
    compared++;
    if (route_err !== 1'b0) begin mismatched++; $display("FAIL reset_route_err: got %b want 0", route_err); end
    compared++;
    if (perf_grants !== 64'd0 || perf_stall !== 32'd0) begin mismatched++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_grants, perf_stall); end
    step();
    reset = 1'b0;
    bus.dram_readdatavalid = 1'b0;
    idle();
  endtask

  task automatic test_single_read();
    logic [511:0] rdata;
    rdata = {16{32'hDA7A_0010}};
    set_client(0, 1'b1, 1'b0, 28'h10, 7'd1);
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b10 || bus.dram_read !== 1'b1 || bus.dram_address !== 28'h10)
      begin mismatched++; $display("FAIL single_grant: got wr=%b rd=%b addr=%h want 10/1/10", bus.cl_waitrequest, bus.dram_read, bus.dram_address); end
    step();
    idle();
    repeat (4) step();
    bus.dram_readdata = rdata;
    bus.dram_readdatavalid = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.cl_readdatavalid !== 2'b01 || bus.cl_readdata !== rdata)
      begin mismatched++; $display("FAIL single_return: got valid=%b data_ok=%0d want 01/1", bus.cl_readdatavalid, bus.cl_readdata === rdata); end
    step();
    bus.dram_readdatavalid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.cl_readdatavalid !== 2'b00 || dut.u_tag_fifo.empty_o !== 1'b1 || route_err !== 1'b0)
      begin mismatched++; $display("FAIL single_after: got valid=%b empty=%b err=%b want 00/1/0", bus.cl_readdatavalid, dut.u_tag_fifo.empty_o, route_err); end
    step();
  endtask

  task automatic test_interleaved();
    logic [1:0] exp_v;
    set_client(0, 1'b1, 1'b0, 28'h100, 7'd4);
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b10) begin mismatched++; $display("FAIL inter_grant0: got %b want 10", bus.cl_waitrequest); end
    step();
    idle();
    set_client(1, 1'b1, 1'b0, 28'h200, 7'd2);
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b01 || bus.dram_burstcount !== 7'd2) begin mismatched++; $display("FAIL inter_grant1: got %b bc=%0d want 01/2", bus.cl_waitrequest, bus.dram_burstcount); end
    step();
    idle();
    for (int b = 0; b < 6; b++) begin
      bus.dram_readdatavalid = 1'b1;
      exp_v = (b < 4) ? 2'b01 : 2'b10;
      @(negedge clk);
      compared++;
      if (bus.cl_readdatavalid !== exp_v) begin mismatched++; $display("FAIL inter_beat%0d: got %b want %b", b, bus.cl_readdatavalid, exp_v); end
      step();
    end
    bus.dram_readdatavalid = 1'b0;
    @(negedge clk);
    compared++;
    if (dut.u_tag_fifo.empty_o !== 1'b1) begin mismatched++; $display("FAIL inter_empty: got %b want 1", dut.u_tag_fifo.empty_o); end
    step();
  endtask

  task automatic test_write_lock();
    logic [511:0] wdata;
    wdata = {16{32'hC1C1_0300}};
    set_client(1, 1'b0, 1'b1, 28'h300, 7'd3);
    bus.cl_writedata[1] = wdata;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b01 || bus.dram_write !== 1'b1 || bus.dram_writedata !== wdata)
      begin mismatched++; $display("FAIL lock_beat1: got wr=%b w=%b want 01/1 with data", bus.cl_waitrequest, bus.dram_write); end
    step();
    // Beat 2 delayed: client drops write, c0 raises an urgent read.
    set_client(0, 1'b1, 1'b0, 28'h400, 7'd1);
    bus.cl_urgent[0] = 1'b1;
    bus.cl_write[1] = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b01 || {bus.dram_read, bus.dram_write} !== 2'b00)
      begin mismatched++; $display("FAIL lock_hold: got wr=%b cmd=%b want 01/00", bus.cl_waitrequest, {bus.dram_read, bus.dram_write}); end
    step();
    bus.cl_write[1] = 1'b1;
    bus.dram_waitrequest = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b11 || bus.dram_write !== 1'b1 || bus.dram_burstcount !== 7'd3)
      begin mismatched++; $display("FAIL lock_stall: got wr=%b w=%b bc=%0d want 11/1/3", bus.cl_waitrequest, bus.dram_write, bus.dram_burstcount); end
    step();
    bus.dram_waitrequest = 1'b0;
    for (int b = 2; b <= 3; b++) begin
      @(negedge clk);
      compared++;
      if (bus.cl_waitrequest !== 2'b01) begin mismatched++; $display("FAIL lock_beat%0d: got %b want 01", b, bus.cl_waitrequest); end
      step();
    end
    bus.cl_write[1] = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b10 || bus.dram_read !== 1'b1 || bus.dram_address !== 28'h400)
      begin mismatched++; $display("FAIL lock_release: got wr=%b rd=%b addr=%h want 10/1/400", bus.cl_waitrequest, bus.dram_read, bus.dram_address); end
    step();
    idle();
    bus.dram_readdatavalid = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.cl_readdatavalid !== 2'b01) begin mismatched++; $display("FAIL lock_return: got %b want 01", bus.cl_readdatavalid); end
    step();
    bus.dram_readdatavalid = 1'b0;
  endtask

  task automatic test_urgent();
    // Round-robin pointer is 1 here; urgent must still pick client 0.
    set_client(0, 1'b1, 1'b0, 28'h500, 7'd1);
    set_client(1, 1'b1, 1'b0, 28'h600, 7'd1);
    bus.cl_urgent = 2'b01;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b10) begin mismatched++; $display("FAIL urgent_pick: got %b want 10", bus.cl_waitrequest); end
    step();
    bus.cl_urgent = 2'b00;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b01 || bus.dram_address !== 28'h600) begin mismatched++; $display("FAIL urgent_rr: got %b addr=%h want 01/600", bus.cl_waitrequest, bus.dram_address); end
    step();
    idle();
    for (int b = 0; b < 2; b++) begin
      bus.dram_readdatavalid = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.cl_readdatavalid !== ((b == 0) ? 2'b01 : 2'b10)) begin mismatched++; $display("FAIL urgent_ret%0d: got %b want %b", b, bus.cl_readdatavalid, (b == 0) ? 2'b01 : 2'b10); end
      step();
    end
    bus.dram_readdatavalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    int               cnt;
    logic [1:0][31:0] exp_grants;
    logic [31:0]      exp_stall;
    set_client(0, 1'b1, 1'b0, 28'h700, 7'd1);
    repeat (16) step();
    set_client(1, 1'b0, 1'b1, 28'h800, 7'd1);
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b01 || {bus.dram_read, bus.dram_write} !== 2'b01)
      begin mismatched++; $display("FAIL full_write: got wr=%b cmd=%b want 01/01", bus.cl_waitrequest, {bus.dram_read, bus.dram_write}); end
    step();
    bus.cl_write[1] = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b11 || bus.dram_read !== 1'b0) begin mismatched++; $display("FAIL full_stall: got wr=%b rd=%b want 11/0", bus.cl_waitrequest, bus.dram_read); end
    step();
    bus.dram_readdatavalid = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.cl_readdatavalid !== 2'b01 || bus.cl_waitrequest !== 2'b11)
      begin mismatched++; $display("FAIL full_pop_cycle: got valid=%b wr=%b want 01/11", bus.cl_readdatavalid, bus.cl_waitrequest); end
    step();
    bus.dram_readdatavalid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b10 || bus.dram_read !== 1'b1) begin mismatched++; $display("FAIL full_freed: got wr=%b rd=%b want 10/1", bus.cl_waitrequest, bus.dram_read); end
    step();
    idle();
    cnt = 0;
    for (int b = 0; b < 13; b++) begin
      bus.dram_readdatavalid = 1'b1;
      @(negedge clk);
      if (bus.cl_readdatavalid === 2'b01) cnt++;
      step();
    end
    bus.dram_readdatavalid = 1'b0;
    compared++;
    if (cnt !== 13) begin mismatched++; $display("FAIL full_drain: got %0d want 13", cnt); end
`ifdef DRAM_ARB_PERF_EN
    exp_grants = {32'd4, 32'd21};
    exp_stall  = 32'd1;
`else
    exp_grants = '0;
    exp_stall  = '0;
`endif
    @(negedge clk);
    compared++;
    if (perf_grants !== exp_grants || perf_stall !== exp_stall)
      begin mismatched++; $display("FAIL perf_counts: got %0d,%0d/%0d want %0d,%0d/%0d", perf_grants[0], perf_grants[1], perf_stall, exp_grants[0], exp_grants[1], exp_stall); end
    step();
  endtask

  task automatic test_error_reset();
    // Three reads are still outstanding at this point.
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.cl_waitrequest !== 2'b11) begin mismatched++; $display("FAIL err_reset_waitreq: got %b want 11", bus.cl_waitrequest); end
    step();
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (dut.u_tag_fifo.empty_o !== 1'b1 || perf_grants !== 64'd0 || perf_stall !== 32'd0)
      begin mismatched++; $display("FAIL err_cleared: got empty=%b grants=%h stall=%0d want 1/0/0", dut.u_tag_fifo.empty_o, perf_grants, perf_stall); end
    step();
    bus.dram_readdatavalid = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.cl_readdatavalid !== 2'b00) begin mismatched++; $display("FAIL err_no_valid: got %b want 00", bus.cl_readdatavalid); end
    step();
    bus.dram_readdatavalid = 1'b0;
    @(negedge clk);
    compared++;
    if (route_err !== 1'b1) begin mismatched++; $display("FAIL err_flag: got %b want 1", route_err); end
    step();
    @(negedge clk);
    compared++;
    if (route_err !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b want 1", route_err); end
  endtask

  initial begin
    bus.cl_read            = '0;
    bus.cl_write           = '0;
    bus.cl_urgent          = '0;
    bus.cl_address         = '0;
    bus.cl_burstcount      = '0;
    bus.cl_writedata       = '0;
    bus.dram_waitrequest   = 1'b0;
    bus.dram_readdata      = '0;
    bus.dram_readdatavalid = 1'b0;

    test_reset();
    test_single_read();
    test_interleaved();
    test_write_lock();
    test_urgent();
    test_fifo_full();
    test_error_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single 512-bit, word-addressed Avalon-MM DRAM master port (EMIF) between NUM_CLIENTS requesters, e.g. the matrix operand reader and the result write-buffer drain.
- Arbitrates commands round-robin, with an urgent override.
- Keeps write bursts atomic.
- Routes returning read beats back to the client that issued the read, using an in-order tag FIFO.
- Sits between the DRAM agent logic and the top-level dram_* ports.

Parameters:
- NUM_CLIENTS, 2, number of requesters; index 0 is lowest urgent priority.
- ADDR_W, 28, DRAM word address width.
- DATA_W, 512, data width.
- BURST_W, 7, burstcount width.
- TAG_DEPTH, 16, maximum outstanding read commands tracked; power of 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cl_read  in  NUM_CLIENTS  per-client read request
- cl_write  in  NUM_CLIENTS  per-client write request
- cl_address  in  NUM_CLIENTS x ADDR_W  per-client address
- cl_burstcount  in  NUM_CLIENTS x BURST_W  per-client burst length
- cl_writedata  in  NUM_CLIENTS x DATA_W  per-client write data
- cl_urgent  in  NUM_CLIENTS  priority override (e.g. write buffer at or above its threshold)
- cl_waitrequest  out  NUM_CLIENTS  per-client stall
- cl_readdatavalid  out  NUM_CLIENTS  routed read-data valid
- cl_readdata  out  DATA_W  dram_readdata broadcast to all clients
- dram_waitrequest  in  1  from EMIF
- dram_readdata  in  DATA_W  from EMIF
- dram_readdatavalid  in  1  from EMIF
- dram_address  out  ADDR_W  to EMIF
- dram_burstcount  out  BURST_W  to EMIF
- dram_writedata  out  DATA_W  to EMIF
- dram_read  out  1  to EMIF
- dram_write  out  1  to EMIF
- route_err  out  1  sticky flag: readdatavalid arrived with the tag FIFO empty
- perf_grants  out  NUM_CLIENTS x 32  per-client accepted-command count (see Optional Feature)
- perf_stall  out  32  DRAM backpressure cycle count (see Optional Feature)

Behaviour:
- Reset values: rr_ptr=0, state=ARB, tag FIFO empty, beat counters 0, route_err=0, perf counters 0.
  - All cl_waitrequest=1 during reset.
  - dram_read=dram_write=0, cl_readdatavalid=0.
- Command path is combinational, zero added latency.
  - The granted client's address, burstcount, writedata, read and write drive dram_*.
  - Granted client: cl_waitrequest = dram_waitrequest.
  - All non-granted clients: cl_waitrequest = 1.
- Eligibility:
  - A client is eligible if cl_write is high, or cl_read is high and the tag FIFO is not full.
  - A client asserting both read and write in one cycle is illegal; the bench asserts on it.
- State ARB:
  - If any eligible client has cl_urgent, grant the highest-index urgent eligible client.
  - Otherwise grant the first eligible client at or after rr_ptr, searching circularly.
  - No eligible client: dram_read=dram_write=0.
- Read accept (dram_read && !dram_waitrequest):
  - Push {client id, burstcount} to the tag FIFO.
  - rr_ptr <= grant+1 mod NUM_CLIENTS.
  - Stay in ARB.
- Write first-beat accept:
  - If burstcount==1: complete, update rr_ptr, stay in ARB.
  - Otherwise: latch the grant, wbeats <= burstcount-1, go to WR_LOCK.
- State WR_LOCK:
  - The grant is frozen to the latched client; cl_urgent is ignored.
  - Each accepted write beat decrements wbeats; dram_burstcount passes through unchanged.
  - When the beat with wbeats==1 is accepted: rr_ptr <= latched+1, return to ARB.
  - The client deasserting write mid-burst simply stalls the lock.
- burstcount==0 is illegal; the bench asserts on it.
- Read return path:
  - On dram_readdatavalid, assert cl_readdatavalid[head.id] in the same cycle.
  - rbeats counts from 0 up to head.burstcount-1; on that last beat, pop the FIFO and clear rbeats.
  - A push and pop in the same cycle are both honoured, and the count is unchanged.
  - A FIFO at full still accepts a pop.
- Error case: readdatavalid with the FIFO empty sets route_err sticky, and no client sees valid.
- Reset mid-operation:
  - Outstanding tags and any write lock are discarded immediately.
  - Stale EMIF returns afterwards set route_err; the owner must drain DRAM before reset.

Optional Feature:
- Macro: DRAM_ARB_PERF_EN.
- Defined:
  - perf_grants[i] increments on each accepted read command, and on each completed write burst, for client i.
  - perf_stall increments every cycle with (dram_read||dram_write) && dram_waitrequest.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package dram_arb_pkg holds:
  - typedef arb_state_t {ARB, WR_LOCK};
  - typedef tag_t {client id, burstcount};
  - localparam CLIENT_ID_W = $clog2(NUM_CLIENTS).
- One sub-module, dram_arb_tag_fifo:
  - Synchronous FIFO of tag_t, depth TAG_DEPTH.
  - Ports: push, pop, full, empty, head.

Test Plan:
- Single read: c0 read addr 0x10, burst 1, EMIF returns after 5 cycles -> cl_readdatavalid[0] pulses once, [1] never, FIFO empty afterwards.
- Interleaved reads: c0 burst 4, c1 burst 2, issued back-to-back -> 4 valids routed to c0, then 2 to c1; rr alternates 0,1.
- Write lock: c1 writes burst 3 while c0 requests a read with cl_urgent[0]=1 -> c0 waitrequest stays high for all 3 beats; c0 is granted the cycle after the 3rd beat.
- Urgent override: c0 and c1 both request reads, rr_ptr=1, cl_urgent[0]=1 -> c0 granted first.
- FIFO full: 16 c0 reads issued with no returns -> 17th read stalled while a c1 write is still granted; the first return frees a slot.
- Error and reset: assert reset with 3 reads outstanding, then inject a readdatavalid -> route_err=1, no cl_readdatavalid; with DRAM_ARB_PERF_EN, perf_grants=0 after reset.
